// File: rtl/rv32i_enc_pkg.sv
// rv32i_enc_pkg: op enum, opcode/funct constants and funct3 lookup for the RV32I encoder
package rv32i_enc_pkg;

  typedef enum logic [5:0] {
    OP_LUI    = 6'd0,  OP_AUIPC  = 6'd1,  OP_JAL    = 6'd2,  OP_JALR   = 6'd3,
    OP_BEQ    = 6'd4,  OP_BNE    = 6'd5,  OP_BLT    = 6'd6,  OP_BGE    = 6'd7,
    OP_BLTU   = 6'd8,  OP_BGEU   = 6'd9,
    OP_LB     = 6'd10, OP_LH     = 6'd11, OP_LW     = 6'd12, OP_LBU    = 6'd13,
    OP_LHU    = 6'd14,
    OP_SB     = 6'd15, OP_SH     = 6'd16, OP_SW     = 6'd17,
    OP_ADDI   = 6'd18, OP_SLTI   = 6'd19, OP_SLTIU  = 6'd20, OP_XORI   = 6'd21,
    OP_ORI    = 6'd22, OP_ANDI   = 6'd23, OP_SLLI   = 6'd24, OP_SRLI   = 6'd25,
    OP_SRAI   = 6'd26,
    OP_ADD    = 6'd27, OP_SUB    = 6'd28, OP_SLL    = 6'd29, OP_SLT    = 6'd30,
    OP_SLTU   = 6'd31, OP_XOR    = 6'd32, OP_SRL    = 6'd33, OP_SRA    = 6'd34,
    OP_OR     = 6'd35, OP_AND    = 6'd36,
    OP_FENCE  = 6'd37, OP_ECALL  = 6'd38, OP_EBREAK = 6'd39,
    OP_CSRRW  = 6'd40, OP_CSRRS  = 6'd41, OP_CSRRC  = 6'd42,
    OP_CSRRWI = 6'd43, OP_CSRRSI = 6'd44, OP_CSRRCI = 6'd45
  } op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP         = 32'h0000_0013;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  // funct3 field for every op that carries one; zero for the rest
  function automatic logic [2:0] f3_of(input logic [5:0] op);
    case (op)
      OP_BNE, OP_LH, OP_SH, OP_SLLI, OP_SLL, OP_CSRRW:             return 3'b001;
      OP_LW, OP_SW, OP_SLTI, OP_SLT, OP_CSRRS:                     return 3'b010;
      OP_SLTIU, OP_SLTU, OP_CSRRC:                                 return 3'b011;
      OP_BLT, OP_LBU, OP_XORI, OP_XOR:                             return 3'b100;
      OP_BGE, OP_LHU, OP_SRLI, OP_SRAI, OP_SRL, OP_SRA, OP_CSRRWI: return 3'b101;
      OP_BLTU, OP_ORI, OP_OR, OP_CSRRSI:                           return 3'b110;
      OP_BGEU, OP_ANDI, OP_AND, OP_CSRRCI:                         return 3'b111;
      default:                                                     return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// enc_fifo: generic synchronous FIFO with occupancy count and synchronous clear
module enc_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // pointer and occupancy update; clear wins over push and pop
  always_comb begin
    wr_d  = clear_i ? '0 : wr_q + AW'(push_i);
    rd_d  = clear_i ? '0 : rd_q + AW'(pop_i);
    cnt_d = clear_i ? '0 : cnt_q + CW'(push_i) - CW'(pop_i);
  end

  // pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // storage needs no reset: the head is only meaningful while count is nonzero
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/rv32i_inst_encoder.sv
// rv32i_inst_encoder: symbolic RV32I request -> machine word + sequential address; ENCODER_ZICSR_EN adds CSR ops
module rv32i_inst_encoder
  import rv32i_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [15:0] word_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   raw_inst, enc_inst, next_addr_q, next_addr_d;
  logic [15:0]   word_count_q, word_count_d;
  logic [2:0]    f3;
  logic [6:0]    f7;
  logic          bad, i_ok, b_ok, j_ok, accept, pop;
  logic [CW-1:0] fifo_count;
  logic [64:0]   head;

  assign i_ok = in_imm[31:11] == {21{in_imm[11]}};
  assign b_ok = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
  assign j_ok = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];

  // combinational encode and legality check; an illegal request becomes a NOP
  always_comb begin
    f3       = f3_of(in_op);
    f7       = (in_op == OP_SUB || in_op == OP_SRA || in_op == OP_SRAI) ? F7_ALT : F7_BASE;
    raw_inst = NOP;
    bad      = 1'b0;
    case (in_op) inside
      OP_LUI, OP_AUIPC: begin
        bad      = |in_imm[11:0];
        raw_inst = {in_imm[31:12], in_rd, (in_op == OP_LUI) ? OPC_LUI : OPC_AUIPC};
      end
      OP_JAL: begin
        bad      = !j_ok;
        raw_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
      end
      OP_JALR: begin
        bad      = !i_ok;
        raw_inst = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
      end
      [OP_BEQ:OP_BGEU]: begin
        bad      = !b_ok;
        raw_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], OPC_BRANCH};
      end
      [OP_LB:OP_LHU]: begin
        bad      = !i_ok;
        raw_inst = {in_imm[11:0], in_rs1, f3, in_rd, OPC_LOAD};
      end
      [OP_SB:OP_SW]: begin
        bad      = !i_ok;
        raw_inst = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], OPC_STORE};
      end
      [OP_ADDI:OP_ANDI]: begin
        bad      = !i_ok;
        raw_inst = {in_imm[11:0], in_rs1, f3, in_rd, OPC_OPIMM};
      end
      [OP_SLLI:OP_SRAI]: begin
        bad      = |in_imm[31:5];
        raw_inst = {f7, in_imm[4:0], in_rs1, f3, in_rd, OPC_OPIMM};
      end
      [OP_ADD:OP_AND]: raw_inst = {f7, in_rs2, in_rs1, f3, in_rd, OPC_OP};
      OP_FENCE: begin
        bad      = |in_imm[31:8];
        raw_inst = {4'b0000, in_imm[7:0], 5'd0, 3'b000, 5'd0, OPC_FENCE};
      end
      OP_ECALL:  raw_inst = INST_ECALL;
      OP_EBREAK: raw_inst = INST_EBREAK;
`ifdef ENCODER_ZICSR_EN
      [OP_CSRRW:OP_CSRRCI]: begin
        bad      = |in_imm[31:12];
        raw_inst = {in_imm[11:0], in_rs1, f3, in_rd, OPC_SYSTEM};
      end
`endif
      default: bad = 1'b1;
    endcase
  end

  assign enc_inst = bad ? NOP : raw_inst;
  assign in_ready = (fifo_count < CW'(FIFO_DEPTH)) && !clear;
  assign accept   = in_valid && in_ready;
  assign out_valid = fifo_count != '0;
  assign pop      = out_valid && out_ready;

  // next address and accepted-word counter; clear reloads both
  always_comb begin
    next_addr_d  = clear ? BASE_ADDR : accept ? next_addr_q + 32'd4 : next_addr_q;
    word_count_d = clear ? 16'd0 : accept ? word_count_q + 16'd1 : word_count_q;
  end

  // address and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_addr_q  <= BASE_ADDR;
      word_count_q <= 16'd0;
    end else begin
      next_addr_q  <= next_addr_d;
      word_count_q <= word_count_d;
    end
  end

  enc_fifo #(.W(65), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear),
    .push_i  (accept),
    .pop_i   (pop),
    .data_i  ({bad, next_addr_q, enc_inst}),
    .data_o  (head),
    .count_o (fifo_count)
  );

  assign out_err    = out_valid && head[64];
  assign out_addr   = out_valid ? head[63:32] : 32'd0;
  assign out_inst   = out_valid ? head[31:0] : 32'd0;
  assign word_count = word_count_q;

endmodule
